// File: rtl/agro_pump_ctrl.sv
// Pump actuator stage: debounces the irrigation demand and enforces minimum
// on/off times plus a maximum on-time that latches a lockout fault.
`timescale 1ns/1ps
module agro_pump_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int MIN_ON     = 64,
    parameter int MIN_OFF    = 64,
    parameter int MAX_ON     = 1024,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       demand_i,
    input  logic       clr_i,
    output logic       pump_o,
    output logic       lockout_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ON       = 2'b01,
        COOLDOWN = 2'b10,
        LOCKOUT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] MAX_ON_LAST  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             demand_db_q, demand_db_d;
    logic             pump_q, lockout_q;

    // A differing input must persist DEB_CYCLES edges; any agreement restarts the count.
    always_comb begin
        demand_db_d = demand_db_q;
        deb_cnt_d   = '0;
        if (demand_i != demand_db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                demand_db_d = demand_i;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en && demand_db_q) state_d = ON;
            end
            // Enable loss beats everything; a normal demand-off exit beats the MAX_ON fault.
            ON: begin
                if (!en) begin
                    state_d = COOLDOWN;
                end else if (!demand_db_q && (timer_q >= MIN_ON_LAST)) begin
                    state_d = COOLDOWN;
                end else if (timer_q == MAX_ON_LAST) begin
                    state_d = LOCKOUT;
                end
            end
            COOLDOWN: begin
                if (timer_q == MIN_OFF_LAST) state_d = IDLE;
            end
            LOCKOUT: begin
                if (clr_i && !demand_db_q) state_d = COOLDOWN;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + CNT_ONE;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            deb_cnt_q   <= '0;
            demand_db_q <= 1'b0;
            pump_q      <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            deb_cnt_q   <= deb_cnt_d;
            demand_db_q <= demand_db_d;
            pump_q      <= (state_d == ON);
            lockout_q   <= (state_d == LOCKOUT);
        end
    end

    assign pump_o    = pump_q;
    assign lockout_o = lockout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_agro_pump_ctrl.sv
// Self-checking bench for agro_pump_ctrl: a cycle model built on "cycles served
// in the current mode" is compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_agro_pump_ctrl;

    localparam int DEB    = 4;
    localparam int MINON  = 8;
    localparam int MINOFF = 6;
    localparam int MAXON  = 32;
    localparam int CW     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       demand_i;
    logic       clr_i;
    logic       pump_o;
    logic       lockout_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0 idle, 1 pumping, 2 cooling, 3 locked out.
    int mDb;
    int mRun;
    int mMode;
    int mServed;
    int newMode;
    bit modelValid = 1'b0;

    int pumpCnt;
    int coolCnt;
    bit pumpSeen;

    always #5 clk = ~clk;

    agro_pump_ctrl #(
        .DEB_CYCLES(DEB),
        .MIN_ON    (MINON),
        .MIN_OFF   (MINOFF),
        .MAX_ON    (MAXON),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .demand_i (demand_i),
        .clr_i    (clr_i),
        .pump_o   (pump_o),
        .lockout_o(lockout_o),
        .state_o  (state_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic d, input logic c, input int n);
        en       = e;
        demand_i = d;
        clr_i    = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        rst_n    = 1'b1;
        pumpCnt  = 0;
        coolCnt  = 0;
        pumpSeen = 1'b0;
    endtask

    // Advance the model on each edge, then compare the DUT shortly after.
    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            mDb        = 0;
            mRun       = 0;
            mMode      = 0;
            mServed    = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            newMode = mMode;
            case (mMode)
                0: if (en && mDb == 1) newMode = 1;
                1: begin
                    if (!en)                                 newMode = 2;
                    else if (mDb == 0 && mServed >= MINON)   newMode = 2;
                    else if (mServed >= MAXON)               newMode = 3;
                end
                2: if (mServed >= MINOFF) newMode = 0;
                3: if (clr_i && mDb == 0) newMode = 2;
                default: newMode = 0;
            endcase
            mServed = (newMode != mMode) ? 1 : mServed + 1;
            mMode   = newMode;
            if (int'(demand_i) != mDb) begin
                mRun++;
                if (mRun >= DEB) begin
                    mDb  = int'(demand_i);
                    mRun = 0;
                end
            end else begin
                mRun = 0;
            end
            if (mMode != 0 && mServed == 0) mServed = 1;
        end
        #1;
        if (modelValid) begin
            checkOutput("cyc_pump",    {31'd0, pump_o},    {31'd0, (mMode == 1)});
            checkOutput("cyc_lockout", {31'd0, lockout_o}, {31'd0, (mMode == 3)});
            checkOutput("cyc_state",   {30'd0, state_o},   32'(mMode));
        end
        if (pump_o === 1'b1) begin
            pumpCnt++;
            pumpSeen = 1'b1;
        end
        if (state_o === 2'b10) coolCnt++;
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        demand_i = 1'b0;
        clr_i    = 1'b0;
        @(negedge clk);

        // Reset state and short glitch rejection, then nominal turn-on latency.
        doReset();
        checkOutput("rst_pump",    {31'd0, pump_o},    0);
        checkOutput("rst_lockout", {31'd0, lockout_o}, 0);
        checkOutput("rst_state",   {30'd0, state_o},   0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        checkOutput("t1_glitch_pump", {31'd0, pumpSeen}, 0);
        checkOutput("t1_glitch_state", {30'd0, state_o}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
        checkOutput("t1_pump_edge4", {31'd0, pump_o}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("t1_pump_edge5", {31'd0, pump_o}, 1);
        checkOutput("t1_model_mode", 32'(mMode), 1);

        // Short demand pulse: pump held for the minimum on-time, then cooldown.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 1'b0, 30);
        checkOutput("t2_pump_cycles", 32'(pumpCnt), 8);
        checkOutput("t2_cool_cycles", 32'(coolCnt), 6);
        checkOutput("t2_state_end",   {30'd0, state_o}, 0);
        checkOutput("t2_model_mode",  32'(mMode), 0);

        // Held demand runs into the maximum on-time and locks out.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 40);
        checkOutput("t3_pump_cycles", 32'(pumpCnt), 32);
        checkOutput("t3_lockout",     {31'd0, lockout_o}, 1);
        checkOutput("t3_state_lock",  {30'd0, state_o}, 3);
        checkOutput("t3_model_mode",  32'(mMode), 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        checkOutput("t3_clr_ignored", {30'd0, state_o}, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        checkOutput("t3_still_lock",  {30'd0, state_o}, 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("t3_cleared",     {30'd0, state_o}, 2);
        checkOutput("t3_lockout_off", {31'd0, lockout_o}, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5);
        checkOutput("t3_cool_hold",   {30'd0, state_o}, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("t3_idle",        {30'd0, state_o}, 0);

        // Enable drop mid-ON forces cooldown; re-enable waits for cooldown to finish.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 5);
        checkOutput("t4_pump_on", {31'd0, pump_o}, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("t4_pump_off", {31'd0, pump_o}, 0);
        checkOutput("t4_state_cool", {30'd0, state_o}, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 5);
        checkOutput("t4_cool_hold", {30'd0, state_o}, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("t4_idle", {30'd0, state_o}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("t4_reenter_on", {30'd0, state_o}, 1);

        // Synchronous reset mid-ON clears everything, including the debounced demand.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 8);
        checkOutput("t5_pump_before", {31'd0, pump_o}, 1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("t5_rst_pump",    {31'd0, pump_o}, 0);
        checkOutput("t5_rst_lockout", {31'd0, lockout_o}, 0);
        checkOutput("t5_rst_state",   {30'd0, state_o}, 0);
        checkOutput("t5_rst_db",      {31'd0, dut.demand_db_q}, 0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
        checkOutput("t5_pump_edge4", {31'd0, pump_o}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("t5_pump_edge5", {31'd0, pump_o}, 1);

        // Demand toggling every two cycles never survives the debounce.
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2);
            applyStimulus(1'b1, 1'b0, 1'b0, 2);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2);
        checkOutput("t6_pump_never", {31'd0, pumpSeen}, 0);
        checkOutput("t6_state",      {30'd0, state_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
